pwm_car4_axil_regs: RTL and testbench
=====================================

// Module: pwm_car4_axil_regs
// PURPOSE
//  AXI4-Lite slave (responder) for the 4-channel PWM car peripheral; answers the master BFM / PS GP port.
//  Holds four 32-bit R/W registers and generates four PWM motor drives plus direction bits from them.
//  Sits between the AXI interconnect and the motor driver pins of the car.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  data bus width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  4   byte address width; word select = ADDR[3:2]
//  PWM_CNT_WIDTH       16  PWM counter / period / duty width (<=16)
// PORTS
//  S_AXI_ACLK     in   1   clock
//  S_AXI_ARESETN  in   1   async active-low reset
//  S_AXI_AWADDR   in   4   write address
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID/AWREADY  in/out 1  write address handshake
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte enables
//  S_AXI_WVALID/WREADY    in/out 1  write data handshake
//  S_AXI_BRESP    out  2   always 2'b00 (OKAY)
//  S_AXI_BVALID/BREADY    out/in 1  write response handshake
//  S_AXI_ARADDR   in   4   read address
//  S_AXI_ARPROT   in   3   ignored
//  S_AXI_ARVALID/ARREADY  in/out 1  read address handshake
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   always 2'b00 (OKAY)
//  S_AXI_RVALID/RREADY    out/in 1  read data handshake
//  pwm_out        out  4   PWM drive, one per wheel
//  dir_out        out  4   direction, one per wheel
// BEHAVIOUR
//  Reset (async assert, deassert sampled on ACLK): all regs 0, all READY/VALID 0, RDATA 0, pwm_out 0, dir_out 0, counter 0.
//  Register map (all bits R/W, read returns exactly what was written):
//   0x0 CTRL: [3:0] enable ch0..3, [7:4] dir ch0..3, [31:8] spare storage
//   0x4 PERIOD: [15:0] period; 0x8 DUTY01: [15:0] ch0, [31:16] ch1; 0xC DUTY23: [15:0] ch2, [31:16] ch3
//  Write channel: AWREADY and WREADY pulse high together for 1 cycle when AWVALID && WVALID && !BVALID && !AWREADY.
//   Register updated in that same cycle, byte lanes per WSTRB (WSTRB=0 -> no change, still OKAY).
//   BVALID rises next cycle, held until BREADY; next write not accepted while BVALID high.
//   AW without W (or W without AW) waits; no partial acceptance.
//  Read channel: ARREADY pulses 1 cycle when ARVALID && !RVALID && !ARREADY; RDATA/RVALID valid next cycle,
//   held stable until RREADY. Read and write channels independent; same-cycle read+write of one register
//   returns the old value.
//  PWM: free counter cnt counts 0..P-1 then wraps to 0, P = active period.
//   Active period/duties are shadow copies loaded from registers only when cnt wraps (cnt==P-1) or when P==0.
//   pwm_out[i] registered = en[i] && (cnt < duty_i); duty >= P -> constantly high; duty 0 -> constantly low.
//   P==0: cnt held 0, pwm_out all 0. dir_out = CTRL[7:4] registered, updates 1 cycle after write (no shadow).
//   Clearing en[i] forces pwm_out[i] low on the next cycle (not at wrap).
//  Reset mid-transaction drops in-flight AXI handshakes; master must reissue.
// TESTING
//  Write 0x0101FFFF/0xABCD0001/0xDEAD0011/0xBEEF0011 to 0x0/0x4/0x8/0xC, read back -> identical data, BRESP=RRESP=0.
//  WSTRB=4'b0010 data 0x0000AA00 to 0x4 after 0xABCD0001 -> readback 0xABCDAA01.
//  PERIOD=10, DUTY01=0x0000_0003, CTRL=0x11 -> pwm_out[0] high 3 of every 10 cycles, dir_out[0]=1, others low.
//  Change DUTY ch0 3->7 mid-period -> old duty finishes current period, 7/10 from next wrap.
//  Hold BREADY low 5 cycles with second AW/W pending -> BVALID stays, second write not accepted until B done.
//  Assert ARESETN low during RVALID -> RVALID, pwm_out drop to 0 immediately; registers read 0 afterwards.

Source files
------------

// File: rtl/pwm_car4_axil_regs.sv
// AXI4-Lite register slave driving four PWM wheel outputs plus direction bits.
// Ports: S_AXI_* AXI4-Lite slave (4-bit byte address, 32-bit data), pwm_out[3:0], dir_out[3:0].
module pwm_car4_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PWM_CNT_WIDTH      = 16
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [3:0]                      pwm_out,
  output logic [3:0]                      dir_out
);

  localparam int NW = PWM_CNT_WIDTH;
  localparam logic [NW-1:0] ONE = {{(NW-1){1'b0}}, 1'b1};

  logic [31:0]   regs_q [4];
  logic [31:0]   regs_d [4];
  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] per_q, per_d;
  logic [NW-1:0] duty_q [4];
  logic [NW-1:0] duty_d [4];
  logic [NW-1:0] duty_reg [4];
  logic [3:0]    pwm_q, pwm_d;
  logic [3:0]    dir_q, dir_d;
  logic          wr_en, rd_en, load;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    awready_d = S_AXI_AWVALID && S_AXI_WVALID
                && !bvalid_q && !awready_q;
    wr_en     = awready_q && S_AXI_AWVALID && S_AXI_WVALID;
    bvalid_d  = wr_en || (bvalid_q && !S_AXI_BREADY);
    regs_d    = regs_q;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b])
          regs_d[S_AXI_AWADDR[3:2]][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read data is taken from regs_q, so a write landing on the
  // same edge is not yet visible: the old value is returned.
  always_comb begin
    arready_d = S_AXI_ARVALID && !rvalid_q && !arready_q;
    rd_en     = arready_q && S_AXI_ARVALID;
    rvalid_d  = rd_en || (rvalid_q && !S_AXI_RREADY);
    rdata_d   = rd_en ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;
  end

  // Period and duties are shadowed and only reloaded at wrap
  // (or continuously while the active period is zero), so a
  // running period always completes with its original settings.
  // Enable and direction act directly from CTRL.
  always_comb begin
    duty_reg[0] = regs_q[2][NW-1:0];
    duty_reg[1] = regs_q[2][16 +: NW];
    duty_reg[2] = regs_q[3][NW-1:0];
    duty_reg[3] = regs_q[3][16 +: NW];
    load  = (per_q == '0) || (cnt_q == per_q - ONE);
    cnt_d = load ? '0 : cnt_q + ONE;
    per_d = load ? regs_q[1][NW-1:0] : per_q;
    for (int i = 0; i < 4; i++) begin
      duty_d[i] = load ? duty_reg[i] : duty_q[i];
      pwm_d[i]  = (per_q != '0) && regs_q[0][i]
                  && (cnt_q < duty_q[i]);
    end
    dir_d = regs_q[0][7:4];
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
        duty_q[i] <= '0;
      end
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      pwm_q     <= '0;
      dir_q     <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
        duty_q[i] <= duty_d[i];
      end
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      pwm_q     <= pwm_d;
      dir_q     <= dir_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign pwm_out       = pwm_q;
  assign dir_out       = dir_q;

endmodule

// File: tb/tb_pwm_car4_axil_regs.sv
// Testbench for pwm_car4_axil_regs: directed AXI/PWM steps plus
// randomized register and PWM configurations against a reference model.
module tb_pwm_car4_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [3:0]  pwm_out;
  logic [3:0]  dir_out;

  always #5 clk = ~clk;

  pwm_car4_axil_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .pwm_out       (pwm_out),
    .dir_out       (dir_out)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] mdl [4];
  logic [3:0]  hist [$];
  int          cnts [4];

  always @(negedge clk) hist.push_back(pwm_out);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    @(posedge clk); #1;
  endtask

  task automatic axi_wr(input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    int k;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (!awready && k < 20);
    chk("awready", {31'b0, awready}, 32'd1);
    chk("wready", {31'b0, wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int b = 0; b < 4; b++)
      if (s[b]) mdl[a[3:2]][8*b +: 8] = d[8*b +: 8];
    chk("bvalid", {31'b0, bvalid}, 32'd1);
    chk("bresp", {30'b0, bresp}, 32'd0);
    @(posedge clk); #1;
    chk("bvalid_clr", {31'b0, bvalid}, 32'd0);
  endtask

  task automatic axi_rd(input logic [3:0] a, output logic [31:0] d);
    int k;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (!arready && k < 20);
    chk("arready", {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid", {31'b0, rvalid}, 32'd1);
    chk("rresp", {30'b0, rresp}, 32'd0);
    d = rdata;
    @(posedge clk); #1;
    chk("rvalid_clr", {31'b0, rvalid}, 32'd0);
  endtask

  task automatic rd_chk(input logic [3:0] a);
    logic [31:0] d;
    axi_rd(a, d);
    chk($sformatf("rdata@%h", a), d, mdl[a[3:2]]);
  endtask

  task automatic count_pwm(input int n);
    for (int i = 0; i < 4; i++) cnts[i] = 0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) cnts[i] += int'(pwm_out[i]);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        prev;
    int          k, idx, s0, s1, p;
    logic [3:0]  en, dr;
    int          du [4];
    logic [1:0]  w;

    mdl_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", {31'b0, awready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_arready", {31'b0, arready}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pwm", {28'b0, pwm_out}, 32'd0);
    chk("rst_dir", {28'b0, dir_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rd_chk(4'(i * 4));

    axi_wr(4'h0, 32'h0101FFFF, 4'hF);
    axi_wr(4'h4, 32'hABCD0001, 4'hF);
    axi_wr(4'h8, 32'hDEAD0011, 4'hF);
    axi_wr(4'hC, 32'hBEEF0011, 4'hF);
    for (int i = 0; i < 4; i++) rd_chk(4'(i * 4));
    axi_wr(4'h4, 32'h0000AA00, 4'b0010);
    axi_rd(4'h4, d);
    chk("wstrb_lane1", d, 32'hABCDAA01);
    axi_wr(4'h4, 32'hFFFFFFFF, 4'b0000);
    axi_rd(4'h4, d);
    chk("wstrb_zero", d, 32'hABCDAA01);

    do_reset();
    axi_wr(4'h4, 32'd10, 4'hF);
    axi_wr(4'h8, 32'h0000_0003, 4'hF);
    axi_wr(4'h0, 32'h11, 4'hF);
    repeat (25) @(negedge clk);
    count_pwm(100);
    chk("pwm0_3of10", 32'(cnts[0]), 32'd30);
    chk("pwm1_off", 32'(cnts[1]), 32'd0);
    chk("pwm23_off", 32'(cnts[2] + cnts[3]), 32'd0);
    chk("dir_0001", {28'b0, dir_out}, 32'h1);

    @(negedge clk); #1;
    prev = pwm_out[0];
    k = 0;
    do begin
      @(negedge clk); #1; k++;
      if (pwm_out[0] && !prev) break;
      prev = pwm_out[0];
    end while (k < 40);
    chk("rise_found", {31'b0, pwm_out[0]}, 32'd1);
    idx = hist.size() - 1;
    axi_wr(4'h8, 32'h0000_0007, 4'hF);
    repeat (25) @(negedge clk);
    s0 = 0; s1 = 0;
    for (int j = 0; j < 10; j++) begin
      s0 += int'(hist[idx + j][0]);
      s1 += int'(hist[idx + 10 + j][0]);
    end
    chk("duty_old_finish", 32'(s0), 32'd3);
    chk("duty_new_after_wrap", 32'(s1), 32'd7);

    axi_wr(4'h0, 32'h10, 4'hF);
    count_pwm(20);
    chk("en_clear_low", 32'(cnts[0]), 32'd0);
    chk("dir_kept", {28'b0, dir_out}, 32'h1);

    bready = 1'b0;
    awaddr = 4'h8; wdata = 32'h11112222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (!awready && k < 20);
    chk("b1_awready", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    mdl[2] = 32'h11112222;
    wdata = 32'h33334444;
    chk("b1_bvalid", {31'b0, bvalid}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("b_hold", {31'b0, bvalid}, 32'd1);
      chk("aw_blocked", {31'b0, awready}, 32'd0);
    end
    rd_chk(4'h8);
    bready = 1'b1;
    @(posedge clk); #1;
    chk("b1_done", {31'b0, bvalid}, 32'd0);
    k = 0;
    while (!awready && k < 20) begin @(posedge clk); #1; k++; end
    chk("b2_awready", {31'b0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    mdl[2] = 32'h33334444;
    chk("b2_bvalid", {31'b0, bvalid}, 32'd1);
    @(posedge clk); #1;
    rd_chk(4'h8);

    for (int it = 0; it < 4; it++) begin
      p  = int'($urandom_range(2, 12));
      en = 4'($urandom_range(0, 15));
      dr = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) du[i] = int'($urandom_range(0, p + 2));
      axi_wr(4'h4, 32'(p), 4'hF);
      axi_wr(4'h8, {16'(du[1]), 16'(du[0])}, 4'hF);
      axi_wr(4'hC, {16'(du[3]), 16'(du[2])}, 4'hF);
      axi_wr(4'h0, {24'h0, dr, en}, 4'hF);
      repeat (30) @(negedge clk);
      count_pwm(5 * p);
      for (int i = 0; i < 4; i++)
        chk($sformatf("rnd%0d_pwm%0d", it, i), 32'(cnts[i]),
            en[i] ? 32'(5 * ((du[i] < p) ? du[i] : p)) : 32'd0);
      chk($sformatf("rnd%0d_dir", it), {28'b0, dir_out}, {28'b0, dr});
    end

    axi_wr(4'h4, 32'd4, 4'hF);
    axi_wr(4'h8, 32'hFFFFFFFF, 4'hF);
    axi_wr(4'h0, 32'hF1, 4'hF);
    repeat (20) @(negedge clk);
    chk("pre_rst_pwm0", {31'b0, pwm_out[0]}, 32'd1);
    chk("pre_rst_dir", {28'b0, dir_out}, 32'hF);
    @(posedge clk); #1;
    rready = 1'b0; araddr = 4'h0; arvalid = 1'b1;
    k = 0;
    do begin @(posedge clk); #1; k++; end
    while (!arready && k < 20);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
    chk("pre_rst_rdata", rdata, 32'hF1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("arst_pwm", {28'b0, pwm_out}, 32'd0);
    chk("arst_dir", {28'b0, dir_out}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rready = 1'b1;
    mdl_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rd_chk(4'(i * 4));

    for (int it = 0; it < 24; it++) begin
      w = 2'($urandom_range(0, 3));
      axi_wr({w, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
      w = 2'($urandom_range(0, 3));
      rd_chk({w, 2'b00});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
